// File: rtl/accum_dump_sequencer.sv
// Wishbone read master that drains correlator results after each accumulation interrupt
// and streams every correlator word to the firmware-side buffer.
module accum_dump_sequencer #(
  parameter int NUM_CH      = 1,
  parameter int CH_STRIDE   = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        hw_rstn,
  input  logic        enable,
  input  logic        accum_int,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_ch,
  output logic [2:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status_o,
  output logic        overrun,
  output logic        timeout_err
);

  // state   | meaning
  // IDLE    | waiting for an accum_int rising edge
  // RD_STAT | reading STATUS (clears the interrupt)
  // RD_NEW  | reading the NEW_DATA channel mask
  // SCAN    | picking the lowest channel still pending
  // RD_COR  | reading correlator word idx of channel cur_ch
  // PUSH    | offering the captured word on the stream
  // FIN     | one-cycle completion, done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_RD_STAT, S_RD_NEW, S_SCAN, S_RD_COR, S_PUSH, S_FIN
  } state_t;

  localparam logic [3:0] TMO_LOAD = 4'(ACK_TIMEOUT - 1);

  state_t            state, state_nx;
  logic              int_q, trig;
  logic              gap, rd_state, req, ack_ok, tmo_hit;
  logic [3:0]        tmo_cnt;
  logic [NUM_CH-1:0] mask, cur_bit;
  logic [2:0]        cur_ch, idx, scan_ch;
  logic              scan_hit;
  logic [7:0]        word;

  assign trig     = accum_int & ~int_q & enable;
  assign rd_state = (state == S_RD_STAT) || (state == S_RD_NEW) || (state == S_RD_COR);
  // the cycle after an ack is a mandatory idle gap on the bus
  assign req      = rd_state & ~gap;
  assign ack_ok   = req & wb_ack_i;
  assign tmo_hit  = req & ~wb_ack_i & (tmo_cnt == 4'd0);

  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        scan_hit = 1'b1;
        scan_ch  = 3'(i);
      end
    end
  end

  always_comb begin
    cur_bit = '0;
    for (int i = 0; i < NUM_CH; i++) cur_bit[i] = (cur_ch == 3'(i));
  end

  always_comb begin
    word = 8'h00;
    case (state)
      S_RD_STAT: word = 8'hE0;
      S_RD_NEW:  word = 8'hE1;
      S_RD_COR:  word = 8'(cur_ch) * 8'(CH_STRIDE) + 8'd4 + 8'(idx);
      default:   word = 8'h00;
    endcase
  end

  assign wb_adr_o  = {22'd0, word, 2'b00};
  assign wb_cyc_o  = req;
  assign wb_stb_o  = req;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'hF;
  assign out_valid = (state == S_PUSH);
  assign out_ch    = cur_ch;
  assign out_idx   = idx;
  assign out_last  = (state == S_PUSH) && (idx == 3'd5) && ((mask & ~cur_bit) == '0);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (trig) state_nx = S_RD_STAT;
      S_RD_STAT: if (tmo_hit) state_nx = S_FIN; else if (gap) state_nx = S_RD_NEW;
      S_RD_NEW:  if (tmo_hit) state_nx = S_FIN; else if (gap) state_nx = S_SCAN;
      S_SCAN:    state_nx = scan_hit ? S_RD_COR : S_FIN;
      S_RD_COR:  if (tmo_hit) state_nx = S_FIN; else if (gap) state_nx = S_PUSH;
      S_PUSH:    if (out_ready) state_nx = (idx == 3'd5) ? S_SCAN : S_RD_COR;
      S_FIN:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      state       <= S_IDLE;
      int_q       <= 1'b0;
      gap         <= 1'b0;
      tmo_cnt     <= TMO_LOAD;
      mask        <= '0;
      cur_ch      <= 3'd0;
      idx         <= 3'd0;
      out_data    <= 32'd0;
      status_o    <= 2'd0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      int_q <= accum_int;
      gap   <= ack_ok;
      if (req && !wb_ack_i && !tmo_hit) tmo_cnt <= tmo_cnt - 4'd1;
      else                              tmo_cnt <= TMO_LOAD;
      if (tmo_hit) timeout_err <= 1'b1;
      if (trig && state != S_IDLE) overrun <= 1'b1;
      if (ack_ok) begin
        case (state)
          S_RD_STAT: status_o <= wb_dat_i[1:0];
          S_RD_NEW:  mask     <= wb_dat_i[NUM_CH-1:0];
          S_RD_COR:  out_data <= wb_dat_i;
          default:   ;
        endcase
      end
      if (state == S_SCAN && scan_hit) begin
        cur_ch <= scan_ch;
        idx    <= 3'd0;
      end
      if (state == S_PUSH && out_ready) begin
        if (idx == 3'd5) mask <= mask & ~cur_bit;
        else             idx  <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_accum_dump_sequencer.sv
// Bench for accum_dump_sequencer: behavioural baseband slave, stream sink and a list-based
// reference of the expected read and stream sequences.
module tb_accum_dump_sequencer;
  localparam int NUM_CH      = 8;
  localparam int CH_STRIDE   = 40;
  localparam int ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        hw_rstn, enable, accum_int;
  logic [31:0] wb_adr_o, wb_dat_i, out_data;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [3:0]  wb_sel_o;
  logic        out_valid, out_ready, out_last, busy, done, overrun, timeout_err;
  logic [2:0]  out_ch, out_idx;
  logic [1:0]  status_o;

  accum_dump_sequencer #(.NUM_CH(NUM_CH), .CH_STRIDE(CH_STRIDE), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .hw_rstn(hw_rstn), .enable(enable), .accum_int(accum_int),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .status_o(status_o),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  logic [31:0] stat_val = 0, new_val = 0, salt = 0;
  int          wait_n = 0, no_ack_word = -1, last_abort_len = 0;
  int          rdy_mode = 0, stall_left = 0;
  logic [31:0] rd_log[$];
  logic [38:0] st_log[$];
  logic        exp_overrun = 0, exp_tmo = 0;
  logic [1:0]  exp_status = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sdata(input logic [7:0] w);
    if (w == 8'hE0) return stat_val;
    if (w == 8'hE1) return new_val;
    return salt + 32'(w) + 32'd13;
  endfunction

  // baseband slave: ack after wait_n extra cycles, ack lasts one cycle
  initial begin : slave
    int wcnt, run;
    logic [31:0] prev_adr;
    wcnt = 0; run = 0; prev_adr = 0;
    wb_ack_i = 0; wb_dat_i = 0;
    forever begin
      @(negedge clk);
      if (!hw_rstn) begin
        wb_ack_i = 0; wcnt = 0; run = 0;
      end else if (wb_ack_i) begin
        chk_eq("gap_after_ack", 64'(wb_cyc_o), 64'd0);
        wb_ack_i = 0;
      end else if (wb_stb_o) begin
        chk_eq("cyc_eq_stb", 64'(wb_cyc_o), 64'(wb_stb_o));
        if (run > 0) chk_eq("adr_hold", 64'(wb_adr_o), 64'(prev_adr));
        run++; wcnt++; prev_adr = wb_adr_o;
        if (wcnt >= wait_n + 2 && int'(wb_adr_o[9:2]) != no_ack_word) begin
          wb_ack_i = 1;
          wb_dat_i = sdata(wb_adr_o[9:2]);
          rd_log.push_back(wb_adr_o);
          wcnt = 0; run = 0;
        end
      end else begin
        if (run > 0) last_abort_len = run;
        run = 0; wcnt = 0;
      end
    end
  end

  // stream sink with selectable backpressure
  initial begin : sink
    logic stall_prev;
    logic [38:0] held;
    stall_prev = 0; held = '0; out_ready = 1;
    forever begin
      @(negedge clk);
      if (!hw_rstn) begin
        stall_prev = 0; out_ready = 1;
      end else begin
        if (stall_prev) begin
          chk_eq("stall_valid", 64'(out_valid), 64'd1);
          chk_eq("stall_hold", 64'({out_data, out_ch, out_idx, out_last}), 64'(held));
          chk_eq("stall_no_bus", 64'(wb_cyc_o), 64'd0);
        end
        case (rdy_mode)
          1: out_ready = 1'($urandom_range(0, 1));
          2: if (out_valid && out_idx == 3'd2 && stall_left > 0) begin
               out_ready = 0; stall_left--;
             end else out_ready = 1;
          default: out_ready = 1;
        endcase
        if (out_valid && out_ready) st_log.push_back({out_data, out_ch, out_idx, out_last});
        stall_prev = out_valid && !out_ready;
        held = {out_data, out_ch, out_idx, out_last};
      end
    end
  end

  task automatic run_seq(input logic [31:0] st, input logic [31:0] nd, input int rmode,
                         input int wn, input int abort_j, input bit reint, input bit drop_en,
                         input bit chk_lat);
    logic [31:0] e_rd[$];
    logic [38:0] e_st[$];
    logic [7:0]  w;
    int k, busy_k, done_k, n_cor;
    bit reint_done, got_done;
    stat_val = st; new_val = nd; salt = $urandom; rdy_mode = rmode; wait_n = wn;
    stall_left = 5; no_ack_word = -1; last_abort_len = 0;
    e_rd.push_back(32'h380);
    e_rd.push_back(32'h384);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (nd[ch]) begin
        for (int i = 0; i < 6; i++) begin
          w = 8'((ch * CH_STRIDE + 4 + i) % 256);
          e_rd.push_back({22'd0, w, 2'b00});
          e_st.push_back({sdata(w), 3'(ch), 3'(i), 1'b0});
        end
      end
    end
    if (e_st.size() > 0) e_st[e_st.size() - 1][0] = 1'b1;
    if (abort_j >= 0) begin
      no_ack_word = int'(e_rd[abort_j][9:2]);
      n_cor = (abort_j > 2) ? abort_j - 2 : 0;
      while (e_rd.size() > abort_j) void'(e_rd.pop_back());
      while (e_st.size() > n_cor) void'(e_st.pop_back());
      exp_tmo = 1;
    end
    if (abort_j != 0) exp_status = st[1:0];
    if (reint) exp_overrun = 1;
    rd_log.delete(); st_log.delete();

    @(negedge clk); accum_int = 1;
    k = 0; busy_k = -1; done_k = -1; reint_done = 0; got_done = 0;
    while (k < 4000 && !got_done) begin
      @(negedge clk); k++;
      if (k == 1 && chk_lat) chk_eq("trig_latency", 64'(wb_cyc_o), 64'd1);
      if (busy && busy_k < 0) busy_k = k;
      if (done) begin got_done = 1; done_k = k; end
      if (drop_en && k == 6) enable = 0;
      if (reint && !reint_done && out_valid && k > 2) begin
        accum_int = 1; reint_done = 1;
      end else accum_int = 0;
    end
    accum_int = 0;
    chk_eq("done_seen", 64'(got_done), 64'd1);
    @(negedge clk);
    chk_eq("done_pulse", 64'(done), 64'd0);
    chk_eq("busy_clear", 64'(busy), 64'd0);
    if (chk_lat) chk_eq("done_latency", 64'(done_k - busy_k), 64'd32);
    repeat (4) @(negedge clk);
    chk_eq("stay_idle", 64'(busy), 64'd0);
    chk_eq("rd_count", 64'(rd_log.size()), 64'(e_rd.size()));
    for (int i = 0; i < e_rd.size() && i < rd_log.size(); i++)
      chk_eq("rd_adr", 64'(rd_log[i]), 64'(e_rd[i]));
    chk_eq("st_count", 64'(st_log.size()), 64'(e_st.size()));
    for (int i = 0; i < e_st.size() && i < st_log.size(); i++)
      chk_eq("st_word", 64'(st_log[i]), 64'(e_st[i]));
    chk_eq("status", 64'(status_o), 64'(exp_status));
    chk_eq("overrun", 64'(overrun), 64'(exp_overrun));
    chk_eq("timeout_err", 64'(timeout_err), 64'(exp_tmo));
    if (abort_j >= 0) chk_eq("abort_stb_len", 64'(last_abort_len), 64'(ACK_TIMEOUT));
    enable = 1; no_ack_word = -1;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    logic [31:0] nd;
    int nreads, ab;
    bit found;
    hw_rstn = 0; enable = 1; accum_int = 0;
    repeat (2) @(negedge clk);
    chk_eq("rst_bus", 64'({wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    chk_eq("rst_sel", 64'(wb_sel_o), 64'hF);
    chk_eq("rst_stream", 64'({out_data, out_valid, out_ch, out_idx, out_last}), 64'd0);
    chk_eq("rst_flags", 64'({busy, done, status_o, overrun, timeout_err}), 64'd0);
    hw_rstn = 1;
    repeat (2) @(negedge clk);

    run_seq(32'h2, 32'h1, 0, 0, -1, 0, 0, 1);
    run_seq($urandom, 32'hFFFF_FF00, 0, 1, -1, 0, 0, 0);
    run_seq($urandom, 32'h0000_0005, 2, 0, -1, 0, 0, 0);
    chk_eq("stall_used", 64'(stall_left), 64'd0);

    rd_log.delete();
    enable = 0;
    @(negedge clk); accum_int = 1;
    repeat (2) @(negedge clk); accum_int = 0;
    repeat (3) @(negedge clk);
    chk_eq("disabled_idle", 64'(busy), 64'd0);
    chk_eq("disabled_no_rd", 64'(rd_log.size()), 64'd0);
    enable = 1;

    for (int it = 0; it < 20; it++) begin
      nd = $urandom;
      nreads = 2 + 6 * $countones(nd[7:0]);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nreads - 1)) : -1;
      run_seq($urandom, nd, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ab, 0,
              1'($urandom_range(0, 1)), 0);
    end

    run_seq($urandom, 32'h0A, 0, 0, -1, 1, 0, 0);
    run_seq($urandom, 32'h1, 0, 0, 1, 0, 0, 0);
    run_seq($urandom, 32'h81, 1, 1, -1, 0, 0, 0);

    stat_val = 32'h3; new_val = 32'h1; salt = 0; wait_n = 0; rdy_mode = 0; no_ack_word = -1;
    @(negedge clk); accum_int = 1;
    @(negedge clk); accum_int = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (wb_cyc_o && wb_adr_o != 32'h380 && wb_adr_o != 32'h384) found = 1;
    end
    chk_eq("reach_rd_cor", 64'(found), 64'd1);
    #2 hw_rstn = 0;
    #1;
    chk_eq("arst_bus", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    chk_eq("arst_valid", 64'(out_valid), 64'd0);
    chk_eq("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    hw_rstn = 1;
    exp_overrun = 0; exp_tmo = 0; exp_status = 0;
    repeat (3) @(negedge clk);
    chk_eq("post_rst_idle", 64'({busy, wb_cyc_o, out_valid}), 64'd0);
    chk_eq("post_rst_flags", 64'({status_o, overrun, timeout_err}), 64'd0);
    run_seq($urandom, 32'h24, 0, 0, -1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/accum_dump_sequencer.md
# accum_dump_sequencer

Wishbone-master controller that drains the tracking-channel correlator results out of the GPS baseband after every accumulation interrupt. On each rising edge of the baseband's `accum_int`, it performs these reads over the baseband slave port:
- STATUS (which clears the interrupt).
- NEW_DATA.
- The six I/Q early/prompt/late words of every channel whose new-data bit is set.

Each correlator word is pushed onto a valid/ready stream toward the firmware-side buffer, so the CPU no longer polls register by register.

## Interface
Parameters:
- `NUM_CH`, 1: number of tracking channels (1..8); width of the NEW_DATA mask used.
- `CH_STRIDE`, 16: word-address stride between channel register blocks; channel n correlators are at word `n*CH_STRIDE + 4 .. +9`.
- `ACK_TIMEOUT`, 15: cycles without `wb_ack_i` before a read is aborted (4-bit counter).

Ports:
- `clk`, in, 1: system clock.
- `hw_rstn`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: level; when 0, triggers are ignored and the FSM finishes the current sequence, then idles.
- `accum_int`, in, 1: baseband accumulation interrupt, level; cleared by the STATUS read.
- `wb_adr_o`, out, 32: byte address = word index << 2.
- `wb_cyc_o` / `wb_stb_o`, out, 1: bus request; always equal.
- `wb_we_o`, out, 1: constant 0.
- `wb_sel_o`, out, 4: constant 4'hF.
- `wb_dat_i`, in, 32: read data, valid on the `wb_ack_i` cycle.
- `wb_ack_i`, in, 1: slave acknowledge.
- `out_valid`, out, 1: stream word available.
- `out_ready`, in, 1: consumer accepts the word when `out_valid & out_ready`.
- `out_data`, out, 32: correlator word (low 16 bits significant).
- `out_ch`, out, 3: channel number.
- `out_idx`, out, 3: 0 = IE, 1 = QE, 2 = IP, 3 = QP, 4 = IL, 5 = QL.
- `out_last`, out, 1: final word of this dump sequence.
- `busy`, out, 1: FSM not in IDLE.
- `done`, out, 1: one-cycle pulse when a sequence completes (normally or by abort).
- `status_o`, out, 2: last STATUS value read.
- `overrun`, out, 1: sticky; set when a trigger edge arrives while busy; cleared only by reset.
- `timeout_err`, out, 1: sticky; set on an ack timeout; cleared only by reset.

## Operation
- **Trigger:** `accum_int` is registered into `int_q`. A trigger is `accum_int & ~int_q & enable`. A trigger while busy sets `overrun` and is otherwise dropped, with no queueing.
- **States and transitions:**
  - IDLE → RD_STAT on trigger.
  - RD_STAT → RD_NEW on ack.
  - RD_NEW → SCAN on ack.
  - SCAN picks the lowest set bit of the remaining mask: if one is found → RD_COR; if the mask is empty → FIN.
  - RD_COR → PUSH on ack.
  - PUSH → RD_COR (next idx) or SCAN (after idx 5, clearing that mask bit) on `out_valid & out_ready`.
  - FIN → IDLE.
- **Read cycle:**
  - In any RD_* state, assert cyc/stb with the address held stable until ack.
  - On the ack cycle, capture `wb_dat_i` and deassert cyc/stb on the next edge.
  - cyc/stb are never asserted in the cycle following an ack. This guarantees a one-cycle gap, because the baseband's ack toggles.
- **Addresses (word):** STATUS 0xE0; NEW_DATA 0xE1; correlator `ch*CH_STRIDE + 4 + idx`. Arithmetic is modulo 256 on the word index, then shifted << 2.
- **Captured values:**
  - `status_o` ← `wb_dat_i[1:0]` from the STATUS read.
  - mask ← `wb_dat_i[NUM_CH-1:0]` from the NEW_DATA read.
- **Stream:**
  - `out_data`, `out_ch`, `out_idx` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
  - `out_last` = 1 only on idx 5 of the highest-numbered set channel.
  - An empty mask produces no stream words, and `done` still pulses.
- **Timeout:**
  - An ack counter runs in every RD_* state.
  - When it reaches `ACK_TIMEOUT` with no ack: drop cyc/stb, set `timeout_err`, go to FIN.
  - No partial `out_last` is produced on an abort.
- **`enable` falling mid-sequence** does not abort the sequence.

## Timing
- **Reset values:** all outputs 0, `wb_sel_o` = 4'hF, state IDLE, `int_q` = 0.
- **Trigger latency:** `accum_int` rises at cycle T → `int_q` = 1 and state RD_STAT at T+1 edge → cyc/stb asserted during T+1.
- **One-wait-state slave** (ack one cycle after stb):
  - Each read takes 2 cycles plus 1 gap.
  - One channel with `out_ready` = 1 takes 3 + 3 + 1 (SCAN) + 6×(3+1) + 1 (FIN) = 32 cycles from RD_STAT entry to `done`.
- `done` and `busy` deassert on the same edge. A trigger edge in that `done` cycle counts as overrun.
- An `out_valid` word is accepted in the cycle where `out_valid & out_ready` = 1. The next read's stb starts the following cycle.

## Test plan
- **Single channel:** `NUM_CH` = 1, model slave returns STATUS = 2 and NEW_DATA = 1, correlator words 0x11..0x16, `out_ready` = 1, pulse `accum_int`.
  - Reads at byte addresses 0x380, 0x384, 0x10..0x24.
  - Six stream words with idx 0..5 and data 0x11..0x16; `out_last` on idx 5.
  - `done` 32 cycles after RD_STAT entry; `status_o` = 2.
- **Empty mask:** NEW_DATA = 0 → exactly two bus reads, no `out_valid`, `done` pulses.
- **Backpressure:** `out_ready` low for 5 cycles on idx 2 → `out_data`/`out_idx` held; no bus activity during the stall; sequence completes with the correct order.
- **Overrun:** a second `accum_int` edge during PUSH → `overrun` = 1; the current sequence completes normally; no second sequence starts.
- **Timeout:** slave never acks NEW_DATA → cyc/stb drop after 15 cycles, `timeout_err` = 1, `done` pulses, FSM returns to IDLE and accepts the next trigger.
- **Async reset mid-sequence:** assert `hw_rstn` = 0 during RD_COR → cyc/stb, `out_valid` and `busy` go to 0 immediately (asynchronously); state is IDLE after release.
